// File: rtl/ifetch_resp.sv
// ifetch_resp -- responder end of the instruction-fetch handshake.
//
// Accepts a fetch request (hs_rd4ls_val + i_pc_nx), reads a word-addressed
// instruction store, and returns the 32-bit instruction in o_in_r together
// with a one-cycle hs_ls4rd_rdy pulse. WAIT_CYC extra wait cycles model slow
// memory; during them o_busy is high and requests are ignored. A back-door
// write port loads the program using the same address decode as fetches.
//
// Parameters:
//   DEPTH    store size in 32-bit words (power of two)
//   BASE     byte address of word 0
//   WAIT_CYC wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   hs_rd4ls_val    fetch request valid
//   i_pc_nx         fetch byte address, sampled with the request
//   hs_ls4rd_rdy    one-cycle pulse: o_in_r holds the requested instruction
//   o_in_r          instruction data, held until the next response
//   o_busy          high while waiting; requests are not accepted
//   o_err           (IFETCH_MISALIGN_ERR_EN only) misaligned/out-of-range
//                   fetch, valid with hs_ls4rd_rdy
//   i_wr_en         back-door store write enable
//   i_wr_addr       back-door byte address
//   i_wr_data       back-door write data
//
// Optional feature: define IFETCH_MISALIGN_ERR_EN to add o_err. Erroring
// fetches (address bits [1:0] non-zero, or out of range) return a NOP.
// Without it, bits [1:0] are ignored and out-of-range fetches return 0.
module ifetch_resp #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] BASE     = 32'h8000_0000,
  parameter int          WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs_rd4ls_val,
  input  logic [31:0] i_pc_nx,
  output logic        hs_ls4rd_rdy,
  output logic [31:0] o_in_r,
  output logic        o_busy,
`ifdef IFETCH_MISALIGN_ERR_EN
  output logic        o_err,
`endif
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [32:0] STORE_BYTES = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_LOAD   = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
`ifdef IFETCH_MISALIGN_ERR_EN
  localparam logic [31:0] NOP         = 32'h0000_0013;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_in_range;
`ifdef IFETCH_MISALIGN_ERR_EN
  logic          r_misalign;
`endif

  // Address decode, shared by fetch and back-door write. The subtraction
  // wraps, so addresses below BASE land far above the store and decode as
  // out of range.
  logic [31:0]   w_pc_off;
  logic [31:0]   w_wr_off;
  logic [AW-1:0] w_pc_idx;
  logic [AW-1:0] w_wr_idx;
  logic          w_pc_in_range;
  logic          w_wr_in_range;

  assign w_pc_off      = i_pc_nx - BASE;
  assign w_wr_off      = i_wr_addr - BASE;
  assign w_pc_idx      = w_pc_off[AW+1:2];
  assign w_wr_idx      = w_wr_off[AW+1:2];
  assign w_pc_in_range = ({1'b0, w_pc_off} < STORE_BYTES);
  assign w_wr_in_range = ({1'b0, w_wr_off} < STORE_BYTES);

  // Instruction store.
  // NOTE: the store has no reset -- its contents survive rst_n and it maps
  // onto plain RAM; only the control state below is reset.
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en && w_wr_in_range) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  // The response reads the store on the edge that enters RESP: from the
  // live request when there are no wait cycles, otherwise from the address
  // latched at acceptance. The read sees the store before any write on the
  // same edge lands (read-first).
  logic          w_accept;
  logic          w_respond;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_in_range;
  logic [31:0]   w_rd_data;

  assign w_accept      = hs_rd4ls_val && (r_state != S_WAIT);
  assign w_respond     = (r_state == S_WAIT) ? (r_cnt == 4'd0)
                                             : (w_accept && (WAIT_CYC == 0));
  assign w_rd_idx      = (r_state == S_WAIT) ? r_idx      : w_pc_idx;
  assign w_rd_in_range = (r_state == S_WAIT) ? r_in_range : w_pc_in_range;

`ifdef IFETCH_MISALIGN_ERR_EN
  logic w_rd_err;
  assign w_rd_err  = !w_rd_in_range ||
                     ((r_state == S_WAIT) ? r_misalign : (i_pc_nx[1:0] != 2'b00));
  assign w_rd_data = w_rd_err ? NOP : r_mem[w_rd_idx];
`else
  assign w_rd_data = w_rd_in_range ? r_mem[w_rd_idx] : 32'h0;
`endif

  // Control FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_in_range   <= 1'b0;
      hs_ls4rd_rdy <= 1'b0;
      o_in_r       <= 32'h0;
      o_busy       <= 1'b0;
`ifdef IFETCH_MISALIGN_ERR_EN
      r_misalign   <= 1'b0;
      o_err        <= 1'b0;
`endif
    end else begin
      // Pulse-type outputs default low; the branches below raise them.
      hs_ls4rd_rdy <= 1'b0;
      o_busy       <= 1'b0;
`ifdef IFETCH_MISALIGN_ERR_EN
      o_err        <= 1'b0;
`endif

      if (w_respond) begin
        hs_ls4rd_rdy <= 1'b1;
        o_in_r       <= w_rd_data;
`ifdef IFETCH_MISALIGN_ERR_EN
        o_err        <= w_rd_err;
`endif
      end

      case (r_state)
        // IDLE and RESP accept identically, which gives back-to-back
        // throughput when the requester keeps hs_rd4ls_val high.
        S_IDLE, S_RESP: begin
          if (hs_rd4ls_val) begin
            r_idx      <= w_pc_idx;
            r_in_range <= w_pc_in_range;
`ifdef IFETCH_MISALIGN_ERR_EN
            r_misalign <= (i_pc_nx[1:0] != 2'b00);
`endif
            if (WAIT_CYC == 0) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= WAIT_LOAD;
              r_state <= S_WAIT;
              o_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt  <= r_cnt - 4'd1;
            o_busy <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_resp.sv
// Testbench for ifetch_resp. Two instances share the clock and reset:
// index 0 has no wait cycles, index 1 has three. Directed vectors cover the
// handshake and boundary cases; a random phase compares both instances
// cycle by cycle against an abstract model (a word array plus the times at
// which each accepted request must be answered).
module tb_ifetch_resp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val     [2];
  logic [31:0] pc      [2];
  logic        wr_en   [2];
  logic [31:0] wr_addr [2];
  logic [31:0] wr_data [2];
  logic        rdy     [2];
  logic [31:0] in_r    [2];
  logic        busy    [2];
`ifdef IFETCH_MISALIGN_ERR_EN
  logic        err     [2];
`endif

  always #5 clk = ~clk;

  ifetch_resp #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYC(0)) u_dut_w0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_rd4ls_val (val[0]),
    .i_pc_nx      (pc[0]),
    .hs_ls4rd_rdy (rdy[0]),
    .o_in_r       (in_r[0]),
    .o_busy       (busy[0]),
`ifdef IFETCH_MISALIGN_ERR_EN
    .o_err        (err[0]),
`endif
    .i_wr_en      (wr_en[0]),
    .i_wr_addr    (wr_addr[0]),
    .i_wr_data    (wr_data[0])
  );

  ifetch_resp #(.DEPTH(DEPTH), .BASE(BASE), .WAIT_CYC(3)) u_dut_w3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .hs_rd4ls_val (val[1]),
    .i_pc_nx      (pc[1]),
    .hs_ls4rd_rdy (rdy[1]),
    .o_in_r       (in_r[1]),
    .o_busy       (busy[1]),
`ifdef IFETCH_MISALIGN_ERR_EN
    .o_err        (err[1]),
`endif
    .i_wr_en      (wr_en[1]),
    .i_wr_addr    (wr_addr[1]),
    .i_wr_data    (wr_data[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: store image and last returned word per instance.
  logic [31:0] mm   [2][DEPTH];
  logic [31:0] held [2];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic in_store(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic logic expect_err(input logic [31:0] a);
`ifdef IFETCH_MISALIGN_ERR_EN
    return !in_store(a) || (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] expect_word(input int d, input logic [31:0] a);
    int idx;
    if (expect_err(a)) return NOP;
    if (!in_store(a)) return 32'h0;
    idx = int'((a - BASE) >> 2);
    return mm[d][idx];
  endfunction

  function automatic logic [31:0] preload_word(input int i);
    if (i == 0) return 32'h0000_0093;
    if (i == 1) return 32'h0010_0113;
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      val[d]     = 1'b0;
      pc[d]      = 32'h0;
      wr_en[d]   = 1'b0;
      wr_addr[d] = 32'h0;
      wr_data[d] = 32'h0;
    end
  endtask

  // Response expected this cycle.
  task automatic expect_resp(input int d, input string name, input logic [31:0] exp,
                             input logic exp_e);
    check({name, ".rdy"}, 32'(rdy[d]), 32'd1);
    check({name, ".data"}, in_r[d], exp);
`ifdef IFETCH_MISALIGN_ERR_EN
    check({name, ".err"}, 32'(err[d]), 32'(exp_e));
`else
    if (exp_e) check({name, ".err_unexpected"}, 32'd0, 32'd1);
`endif
    held[d] = exp;
  endtask

  // No response this cycle; data must hold its last value.
  task automatic expect_quiet(input int d, input string name);
    check({name, ".rdy"}, 32'(rdy[d]), 32'd0);
    check({name, ".hold"}, in_r[d], held[d]);
`ifdef IFETCH_MISALIGN_ERR_EN
    check({name, ".err"}, 32'(err[d]), 32'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    held[0] = 32'h0;
    held[1] = 32'h0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset.rdy", 32'(rdy[d]), 32'd0);
      check("reset.busy", 32'(busy[d]), 32'd0);
      check("reset.data", in_r[d], 32'h0);
    end
    rst_n = 1'b1;
    step();

    // Back-door preload of both stores.
    for (int i = 0; i < DEPTH; i++) begin
      for (int d = 0; d < 2; d++) begin
        wr_en[d]   = 1'b1;
        wr_addr[d] = BASE + 32'(4 * i);
        wr_data[d] = preload_word(i);
        mm[d][i]   = preload_word(i);
      end
      step();
    end
    clear_inputs();
    step();

    // Back-to-back table on the zero-wait instance, valid held high.
    vecs[0] = '{32'h8000_0000, 32'h0000_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0010_0113, 1'b0};
    vecs[2] = '{32'h8000_0008, 32'hC0DE_0002, 1'b0};
    vecs[3] = '{32'h8000_00FC, 32'hC0DE_003F, 1'b0};
    vecs[4] = '{32'h8000_0100, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h9000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'h8000_0002, 32'h0000_0093, 1'b1};
    for (int i = 0; i < 8; i++) begin
      val[0] = 1'b1;
      pc[0]  = vecs[i].addr;
      step();
`ifdef IFETCH_MISALIGN_ERR_EN
      expect_resp(0, $sformatf("vec%0d", i), vecs[i].err ? NOP : vecs[i].data, vecs[i].err);
`else
      expect_resp(0, $sformatf("vec%0d", i), vecs[i].data, 1'b0);
`endif
      check($sformatf("vec%0d.busy", i), 32'(busy[0]), 32'd0);
    end
    val[0] = 1'b0;
    step();
    expect_quiet(0, "after_vec");
    step();
    expect_quiet(0, "after_vec2");

    // Back-door write in the same cycle as a fetch of the same word.
    val[0]     = 1'b1;
    pc[0]      = BASE + 32'h8;
    wr_en[0]   = 1'b1;
    wr_addr[0] = BASE + 32'h8;
    wr_data[0] = 32'hDEAD_BEEF;
    step();
    expect_resp(0, "rdfirst.old", 32'hC0DE_0002, 1'b0);
    mm[0][2] = 32'hDEAD_BEEF;
    wr_en[0] = 1'b0;
    step();
    expect_resp(0, "rdfirst.new", 32'hDEAD_BEEF, 1'b0);
    val[0] = 1'b0;
    step();
    expect_quiet(0, "rdfirst.idle");

    // Out-of-range back-door write must not alias onto word 0.
    wr_en[0]   = 1'b1;
    wr_addr[0] = BASE + 32'(DEPTH * 4);
    wr_data[0] = 32'hBAD0_BAD0;
    step();
    wr_en[0] = 1'b0;
    val[0]   = 1'b1;
    pc[0]    = BASE;
    step();
    expect_resp(0, "oor_write", 32'h0000_0093, 1'b0);
    val[0] = 1'b0;
    step();

    // Three wait cycles; a request presented during WAIT is ignored.
    val[1] = 1'b1;
    pc[1]  = BASE + 32'h4;
    step();
    pc[1] = BASE;
    check("wait.busy1", 32'(busy[1]), 32'd1);
    expect_quiet(1, "wait.c1");
    step();
    val[1] = 1'b0;
    check("wait.busy2", 32'(busy[1]), 32'd1);
    expect_quiet(1, "wait.c2");
    step();
    check("wait.busy3", 32'(busy[1]), 32'd1);
    expect_quiet(1, "wait.c3");
    step();
    check("wait.busy4", 32'(busy[1]), 32'd0);
    expect_resp(1, "wait.resp", 32'h0010_0113, 1'b0);
    step();
    check("wait.busy5", 32'(busy[1]), 32'd0);
    expect_quiet(1, "wait.after");
    step();
    expect_quiet(1, "wait.after2");

    // Asynchronous reset in the middle of WAIT.
    val[1] = 1'b1;
    pc[1]  = BASE + 32'h4;
    step();
    val[1] = 1'b0;
    step();
    check("rst.pre_busy", 32'(busy[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.rdy", 32'(rdy[1]), 32'd0);
    check("rst.busy", 32'(busy[1]), 32'd0);
    check("rst.data", in_r[1], 32'h0);
    check("rst.data_w0", in_r[0], 32'h0);
    held[0] = 32'h0;
    held[1] = 32'h0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      expect_quiet(1, $sformatf("rst.quiet%0d", k));
      check($sformatf("rst.busy%0d", k), 32'(busy[1]), 32'd0);
    end

    // Stores survive reset.
    val[0] = 1'b1;
    pc[0]  = BASE;
    val[1] = 1'b1;
    pc[1]  = BASE + 32'h4;
    step();
    val[0] = 1'b0;
    val[1] = 1'b0;
    expect_resp(0, "keep.w0", 32'h0000_0093, 1'b0);
    step();
    step();
    step();
    expect_resp(1, "keep.w3", 32'h0010_0113, 1'b0);
    step();
    step();

    // Random traffic against the abstract model.
    begin
      int          free_at [2];
      int          read_at [2];
      logic [31:0] rd_addr [2];
      logic        exp_rdy [2];
      logic        exp_busy[2];
      logic        exp_e   [2];
      for (int d = 0; d < 2; d++) begin
        free_at[d] = 0;
        read_at[d] = -1;
        rd_addr[d] = 32'h0;
        exp_e[d]   = 1'b0;
      end
      for (int t = 0; t < 400; t++) begin
        for (int d = 0; d < 2; d++) begin
          val[d] = ($urandom_range(0, 9) < 7);
          case ($urandom_range(0, 9))
            0:       pc[d] = $urandom;
            1:       pc[d] = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            default: pc[d] = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
          endcase
          wr_en[d]   = ($urandom_range(0, 3) == 0);
          wr_addr[d] = ($urandom_range(0, 7) == 0) ? $urandom
                                                   : BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
          wr_data[d] = $urandom;

          // A request is taken whenever the previous one has been answered;
          // its word is read wait_of(d) cycles later, before this cycle's write.
          exp_rdy[d] = 1'b0;
          if (val[d] && t >= free_at[d]) begin
            free_at[d] = t + 1 + wait_of(d);
            read_at[d] = t + wait_of(d);
            rd_addr[d] = pc[d];
          end
          if (read_at[d] == t) begin
            exp_rdy[d] = 1'b1;
            held[d]    = expect_word(d, rd_addr[d]);
            exp_e[d]   = expect_err(rd_addr[d]);
          end
          exp_busy[d] = (t + 1 < free_at[d]);
          if (wr_en[d] && in_store(wr_addr[d])) begin
            mm[d][int'((wr_addr[d] - BASE) >> 2)] = wr_data[d];
          end
        end
        step();
        for (int d = 0; d < 2; d++) begin
          check($sformatf("rnd%0d.t%0d.rdy", d, t), 32'(rdy[d]), 32'(exp_rdy[d]));
          check($sformatf("rnd%0d.t%0d.busy", d, t), 32'(busy[d]), 32'(exp_busy[d]));
          check($sformatf("rnd%0d.t%0d.data", d, t), in_r[d], held[d]);
`ifdef IFETCH_MISALIGN_ERR_EN
          check($sformatf("rnd%0d.t%0d.err", d, t), 32'(err[d]),
                32'(exp_rdy[d] && exp_e[d]));
`endif
        end
      end
    end
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
